// File: rtl/id_ex_stage_pkg.sv
// Shared core encodings and the D->E control bundle used by the ID/EX pipeline register.
package id_ex_stage_pkg;

    // Writeback (RegWrite) encodings
    localparam logic [2:0] NOREGWRITE = 3'd0;
    localparam logic [2:0] LB         = 3'd1;
    localparam logic [2:0] LH         = 3'd2;
    localparam logic [2:0] LW         = 3'd3;
    localparam logic [2:0] LBU        = 3'd4;
    localparam logic [2:0] LHU        = 3'd5;

    // Branch type encodings
    localparam logic [2:0] NOBRANCH = 3'd0;
    localparam logic [2:0] BEQ      = 3'd1;
    localparam logic [2:0] BNE      = 3'd2;
    localparam logic [2:0] BLT      = 3'd3;
    localparam logic [2:0] BLTU     = 3'd4;
    localparam logic [2:0] BGE      = 3'd5;
    localparam logic [2:0] BGEU     = 3'd6;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd9;
    localparam logic [3:0] ALU_OR  = 4'd8;

    typedef struct packed {
        logic       valid;
        logic       jal;
        logic       jalr;
        logic       mem_to_reg;
        logic       load_npc;
        logic       alu_src1;
        logic       pred_taken;
        logic [2:0] reg_write;
        logic [3:0] mem_write;
        logic [1:0] reg_read;
        logic [2:0] branch_type;
        logic [3:0] alu_ctrl;
        logic [1:0] alu_src2;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ctrl_t;

    // Bubble: a no-op that writes nothing, stores nothing and never branches.
    localparam ctrl_t BUBBLE_CTRL = '{reg_write: NOREGWRITE, branch_type: NOBRANCH, default: '0};

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detect: a load in EX whose destination is read by the instruction in ID.
module load_use_detect (
    input  logic       valid_e_i,
    input  logic       mem_to_reg_e_i,
    input  logic [4:0] rd_e_i,
    input  logic       valid_d_i,
    input  logic [4:0] rs1_d_i,
    input  logic [4:0] rs2_d_i,
    input  logic [1:0] reg_read_d_i,
    output logic       lu_o
);

    logic rs1_hit, rs2_hit;

    assign rs1_hit = reg_read_d_i[1] & (rs1_d_i == rd_e_i);
    assign rs2_hit = reg_read_d_i[0] & (rs2_d_i == rd_e_i);
    // x0 is never a real producer, so it cannot create a hazard.
    assign lu_o    = valid_e_i & mem_to_reg_e_i & (rd_e_i != 5'd0) & (rs1_hit | rs2_hit) & valid_d_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and saturating bubble/flush counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic             valid_d,
    input  logic             JalD,
    input  logic             JalrD,
    input  logic             MemToRegD,
    input  logic             LoadNpcD,
    input  logic             AluSrc1D,
    input  logic             PredTakenD,
    input  logic [2:0]       RegWriteD,
    input  logic [3:0]       MemWriteD,
    input  logic [1:0]       RegReadD,
    input  logic [2:0]       BranchTypeD,
    input  logic [3:0]       AluContrlD,
    input  logic [1:0]       AluSrc2D,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  ImmD,
    input  logic [XLEN-1:0]  RegOut1D,
    input  logic [XLEN-1:0]  RegOut2D,
    output logic             valid_e,
    output logic             JalE,
    output logic             JalrE,
    output logic             MemToRegE,
    output logic             LoadNpcE,
    output logic             AluSrc1E,
    output logic             PredTakenE,
    output logic [2:0]       RegWriteE,
    output logic [3:0]       MemWriteE,
    output logic [1:0]       RegReadE,
    output logic [2:0]       BranchTypeE,
    output logic [3:0]       AluContrlE,
    output logic [1:0]       AluSrc2E,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  ImmE,
    output logic [XLEN-1:0]  RegOut1E,
    output logic [XLEN-1:0]  RegOut2E,
    output logic             stall_fd,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_t            ctrl_d, ctrl_q;
    logic [XLEN-1:0]  pc_q, imm_q, op1_q, op2_q;
    logic [CNT_W-1:0] bubble_cnt_q, flush_cnt_q;
    logic             lu, load_bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    load_use_detect u_load_use_detect (
        .valid_e_i      (ctrl_q.valid),
        .mem_to_reg_e_i (ctrl_q.mem_to_reg),
        .rd_e_i         (ctrl_q.rd),
        .valid_d_i      (valid_d),
        .rs1_d_i        (Rs1D),
        .rs2_d_i        (Rs2D),
        .reg_read_d_i   (RegReadD),
        .lu_o           (lu)
    );

    // A flushed D slot is wrong-path, so it must not hold IF/ID.
    assign stall_fd = lu & ~flush_e & ~rst;

    always_comb begin
        ctrl_d = '{valid: valid_d, jal: JalD, jalr: JalrD, mem_to_reg: MemToRegD,
                   load_npc: LoadNpcD, alu_src1: AluSrc1D, pred_taken: PredTakenD,
                   reg_write: RegWriteD, mem_write: MemWriteD, reg_read: RegReadD,
                   branch_type: BranchTypeD, alu_ctrl: AluContrlD, alu_src2: AluSrc2D,
                   rs1: Rs1D, rs2: Rs2D, rd: RdD};
        // Hold beats load-use; the bubble lands on the first non-stalled edge.
        load_bubble = rst | flush_e | (~stall_e & lu);
    end

    always_ff @(posedge clk) begin
        if (load_bubble) begin
            ctrl_q <= BUBBLE_CTRL;
            pc_q   <= '0;
            imm_q  <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
        end else if (!stall_e) begin
            ctrl_q <= ctrl_d;
            pc_q   <= PCD;
            imm_q  <= ImmD;
            op1_q  <= RegOut1D;
            op2_q  <= RegOut2D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else if (flush_e) begin
            flush_cnt_q  <= sat_inc(flush_cnt_q);
        end else if (!stall_e && lu) begin
            bubble_cnt_q <= sat_inc(bubble_cnt_q);
        end
    end

    assign valid_e     = ctrl_q.valid;
    assign JalE        = ctrl_q.jal;
    assign JalrE       = ctrl_q.jalr;
    assign MemToRegE   = ctrl_q.mem_to_reg;
    assign LoadNpcE    = ctrl_q.load_npc;
    assign AluSrc1E    = ctrl_q.alu_src1;
    assign PredTakenE  = ctrl_q.pred_taken;
    assign RegWriteE   = ctrl_q.reg_write;
    assign MemWriteE   = ctrl_q.mem_write;
    assign RegReadE    = ctrl_q.reg_read;
    assign BranchTypeE = ctrl_q.branch_type;
    assign AluContrlE  = ctrl_q.alu_ctrl;
    assign AluSrc2E    = ctrl_q.alu_src2;
    assign Rs1E        = ctrl_q.rs1;
    assign Rs2E        = ctrl_q.rs2;
    assign RdE         = ctrl_q.rd;
    assign PCE         = pc_q;
    assign ImmE        = imm_q;
    assign RegOut1E    = op1_q;
    assign RegOut2E    = op2_q;
    assign bubble_cnt  = bubble_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use/flush/stall/reset scenarios plus random traffic vs a behavioural model.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    typedef struct packed {
        logic        valid, jal, jalr, m2r, lnpc, as1, pt;
        logic [2:0]  rw;
        logic [3:0]  mw;
        logic [1:0]  rr;
        logic [2:0]  bt;
        logic [3:0]  ac;
        logic [1:0]  as2;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc, imm, r1, r2;
    } st_t;

    logic clk = 1'b0;
    logic rst, stall_e, flush_e;
    st_t  d;

    logic             valid_e, JalE, JalrE, MemToRegE, LoadNpcE, AluSrc1E, PredTakenE;
    logic [2:0]       RegWriteE, BranchTypeE;
    logic [3:0]       MemWriteE, AluContrlE;
    logic [1:0]       RegReadE, AluSrc2E;
    logic [4:0]       Rs1E, Rs2E, RdE;
    logic [XLEN-1:0]  PCE, ImmE, RegOut1E, RegOut2E;
    logic             stall_fd;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;
    st_t              act;

    assign act = {valid_e, JalE, JalrE, MemToRegE, LoadNpcE, AluSrc1E, PredTakenE,
                  RegWriteE, MemWriteE, RegReadE, BranchTypeE, AluContrlE, AluSrc2E,
                  Rs1E, Rs2E, RdE, PCE, ImmE, RegOut1E, RegOut2E};

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e), .valid_d(d.valid),
        .JalD(d.jal), .JalrD(d.jalr), .MemToRegD(d.m2r), .LoadNpcD(d.lnpc),
        .AluSrc1D(d.as1), .PredTakenD(d.pt), .RegWriteD(d.rw), .MemWriteD(d.mw),
        .RegReadD(d.rr), .BranchTypeD(d.bt), .AluContrlD(d.ac), .AluSrc2D(d.as2),
        .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd), .PCD(d.pc), .ImmD(d.imm),
        .RegOut1D(d.r1), .RegOut2D(d.r2),
        .valid_e(valid_e), .JalE(JalE), .JalrE(JalrE), .MemToRegE(MemToRegE),
        .LoadNpcE(LoadNpcE), .AluSrc1E(AluSrc1E), .PredTakenE(PredTakenE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .RegReadE(RegReadE),
        .BranchTypeE(BranchTypeE), .AluContrlE(AluContrlE), .AluSrc2E(AluSrc2E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .ImmE(ImmE),
        .RegOut1E(RegOut1E), .RegOut2E(RegOut2E),
        .stall_fd(stall_fd), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    st_t bub, em;
    int  bc, fc;
    int  vectors = 0;
    int  miscompares = 0;

    task automatic chk(input string name, input logic [255:0] a, input logic [255:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    function automatic logic model_lu();
        return em.valid && em.m2r && (em.rd != 5'd0) && d.valid &&
               ((d.rr[1] && d.rs1 == em.rd) || (d.rr[0] && d.rs2 == em.rd));
    endfunction

    // One clock: check the combinational stall, advance the model, check registered state.
    task automatic cycle();
        logic lu_now;
        #1;
        lu_now = model_lu();
        chk("stall_fd", stall_fd, lu_now && !flush_e && !rst);
        @(posedge clk);
        if (rst) begin
            em = bub; bc = 0; fc = 0;
        end else if (flush_e) begin
            em = bub; if (fc < CMAX) fc++;
        end else if (stall_e) begin
            em = em;
        end else if (lu_now) begin
            em = bub; if (bc < CMAX) bc++;
        end else begin
            em = d;
        end
        @(negedge clk);
        chk("e_regs", act, em);
        chk("bubble_cnt", bubble_cnt, bc);
        chk("flush_cnt", flush_cnt, fc);
    endtask

    task automatic mk_load(input logic [4:0] rd);
        d = '0; d.valid = 1'b1; d.m2r = 1'b1; d.rw = LW; d.rd = rd;
        d.rs1 = 5'd1; d.rr = 2'b10; d.imm = 32'h0; d.pc = $urandom;
    endtask

    task automatic mk_use(input logic [1:0] rr, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd);
        d = '0; d.valid = 1'b1; d.rw = 3'($urandom_range(1, 7)); d.rr = rr;
        d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.ac = ALU_ADD;
        d.pc = $urandom; d.r1 = $urandom; d.r2 = $urandom;
    endtask

    task automatic rnd_d();
        d.valid = ($urandom_range(0, 3) != 0);
        d.jal = 1'($urandom); d.jalr = 1'($urandom); d.m2r = 1'($urandom);
        d.lnpc = 1'($urandom); d.as1 = 1'($urandom); d.pt = 1'($urandom);
        d.rw = 3'($urandom); d.mw = 4'($urandom); d.rr = 2'($urandom);
        d.bt = 3'($urandom); d.ac = 4'($urandom); d.as2 = 2'($urandom);
        d.rs1 = 5'($urandom_range(0, 3)); d.rs2 = 5'($urandom_range(0, 3));
        d.rd = 5'($urandom_range(0, 3));
        d.pc = $urandom; d.imm = $urandom; d.r1 = $urandom; d.r2 = $urandom;
    endtask

    initial begin
        logic last;
        bub = '0; bub.rw = NOREGWRITE; bub.bt = NOBRANCH;
        em = bub; bc = 0; fc = 0;
        d = '0; rst = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
        chk("rst_valid_e", valid_e, 0);
        chk("rst_regwrite", RegWriteE, NOREGWRITE);
        chk("rst_bubble_cnt", bubble_cnt, 0);

        // store passes straight through
        d = '0; d.valid = 1'b1; d.mw = 4'b1111; d.imm = 32'h10; d.pc = 32'h100;
        d.rs1 = 5'd2; d.rs2 = 5'd3; d.rr = 2'b11;
        cycle();
        chk("sw_memwrite", MemWriteE, 4'b1111);
        chk("sw_imm", ImmE, 32'h10);
        chk("sw_pc", PCE, 32'h100);
        chk("sw_valid", valid_e, 1);

        // lw x5 then add x6,x5,x2
        mk_load(5'd5); cycle();
        mk_use(2'b11, 5'd5, 5'd2, 5'd6);
        #1 chk("lu_stall_fd", stall_fd, 1);
        cycle();
        chk("lu_bubble_valid", valid_e, 0);
        chk("lu_bubble_regwrite", RegWriteE, NOREGWRITE);
        chk("lu_bubble_cnt", bubble_cnt, 1);
        cycle();
        chk("lu_use_rd", RdE, 6);
        chk("lu_use_valid", valid_e, 1);

        // x0 destination, then I-type reading only rs1
        mk_load(5'd0); cycle();
        mk_use(2'b11, 5'd0, 5'd0, 5'd7);
        #1 chk("x0_stall_fd", stall_fd, 0);
        cycle();
        chk("x0_pass_rd", RdE, 7);
        mk_load(5'd7); cycle();
        mk_use(2'b10, 5'd3, 5'd7, 5'd8);
        #1 chk("itype_stall_fd", stall_fd, 0);
        cycle();
        chk("itype_pass_rd", RdE, 8);

        // flush with a pending load-use
        mk_load(5'd5); cycle();
        mk_use(2'b01, 5'd1, 5'd5, 5'd9);
        flush_e = 1'b1;
        #1 chk("flush_stall_fd", stall_fd, 0);
        cycle();
        flush_e = 1'b0;
        chk("flush_cnt_one", flush_cnt, 1);
        chk("flush_bubble_cnt", bubble_cnt, 1);
        chk("flush_valid", valid_e, 0);

        // three-cycle hold with a pending load-use
        mk_load(5'd5); cycle();
        mk_use(2'b10, 5'd5, 5'd0, 5'd10);
        stall_e = 1'b1;
        repeat (3) begin
            #1 chk("hold_stall_fd", stall_fd, 1);
            cycle();
            chk("hold_rd", RdE, 5);
            chk("hold_m2r", MemToRegE, 1);
        end
        stall_e = 1'b0;
        cycle();
        chk("hold_then_bubble", valid_e, 0);
        chk("hold_bubble_cnt", bubble_cnt, 2);
        cycle();
        chk("hold_use_rd", RdE, 10);

        // drive bubble_cnt past its ceiling
        repeat (20) begin
            mk_load(5'd4); cycle();
            mk_use(2'b11, 5'd4, 5'd4, 5'd1); cycle(); cycle();
        end
        chk("sat_bubble_cnt", bubble_cnt, 4'hf);

        // reset on top of a stalled load-use
        mk_load(5'd5); cycle();
        mk_use(2'b11, 5'd5, 5'd5, 5'd3);
        rst = 1'b1; stall_e = 1'b1;
        #1 chk("rst_mid_stall_fd", stall_fd, 0);
        cycle();
        rst = 1'b0; stall_e = 1'b0;
        chk("rst2_valid", valid_e, 0);
        chk("rst2_pc", PCE, 0);
        chk("rst2_bubble_cnt", bubble_cnt, 0);
        chk("rst2_flush_cnt", flush_cnt, 0);

        // random traffic; IF/ID hold D while stall_fd is up
        last = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            flush_e = ($urandom_range(0, 7) == 0);
            stall_e = ($urandom_range(0, 5) == 0);
            if (!last) rnd_d();
            last = model_lu() && !flush_e && !rst;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and execute in the 5-stage RV32I core. Captures the decoder's control fields plus decode-stage operands into execute-stage copies. Detects load-use hazards against the instruction already in EX and inserts a bubble, requesting a fetch/decode stall. Keeps saturating event counters for bubbles and flushes.

## Interface
- `XLEN`, 32, datapath width (PC, immediate, operands).
- `CNT_W`, 32, width of event counters.
- `clk` input 1: core clock.
- `rst` input 1: synchronous, active-high reset.
- `stall_e` input 1: hold EX contents (downstream back-pressure).
- `flush_e` input 1: squash D→E transfer (mispredict/jump redirect resolved in EX).
- `valid_d` input 1: D slot holds a real instruction.
- `JalD`, `JalrD`, `MemToRegD`, `LoadNpcD`, `AluSrc1D`, `PredTakenD` input 1 each: decoder/predictor flags.
- `RegWriteD` input 3; `MemWriteD` input 4; `RegReadD` input 2 (bit1 = rs1 used, bit0 = rs2 used); `BranchTypeD` input 3; `AluContrlD` input 4; `AluSrc2D` input 2.
- `Rs1D`, `Rs2D`, `RdD` input 5 each; `PCD`, `ImmD`, `RegOut1D`, `RegOut2D` input XLEN each.
- Matching `...E` outputs for every field above (same widths), plus `valid_e` output 1.
- `stall_fd` output 1: combinational load-use stall request to IF and ID registers.
- `bubble_cnt`, `flush_cnt` output CNT_W: event counters.

## Operation
- Load-use detect (combinational): `lu = valid_e & MemToRegE & (RdE != 0) & ((RegReadD[1] & Rs1D == RdE) | (RegReadD[0] & Rs2D == RdE)) & valid_d`.
- `stall_fd = lu & ~flush_e & ~rst`.
- Per-cycle update priority, highest first:
  1. `rst`: bubble loaded, counters cleared.
  2. `flush_e`: bubble loaded, `flush_cnt` += 1.
  3. `stall_e`: all E registers hold; no bubble; counters hold.
  4. `lu`: bubble loaded, `bubble_cnt` += 1.
  5. Otherwise: every D field copied to E; `valid_e <= valid_d`.
- Bubble: `valid_e=0`, `RegWriteE=NOREGWRITE`, `MemWriteE=4'b0000`, `BranchTypeE=NOBRANCH`, `JalE=JalrE=LoadNpcE=MemToRegE=PredTakenE=0`. All other fields, including PC/Imm/operands/register indices, are zero.
- Counters saturate at all-ones and never wrap.
- An x0 destination never triggers a stall. A load with `valid_e=0` never triggers a stall.

## Timing
- Latency: one cycle D→E.
- `stall_fd` is same-cycle combinational. While asserted, IF/ID hold, so the same D instruction is presented next cycle. Against the bubble, `lu` = 0, so exactly one bubble is inserted per load-use pair.
- `stall_e` together with `lu`: hold wins. `lu` stays asserted (E is unchanged). The bubble is inserted on the first cycle `stall_e` drops.
- `flush_e` together with `lu`: flush wins. `stall_fd` = 0, because the D instruction is wrong-path. Only `flush_cnt` increments.
- Reset value of every output is the bubble value, with both counters 0. `stall_fd` is 0 during `rst`. Reset asserted mid-stall clears the pipeline on the next edge.

## Structure
- `NOREGWRITE`, `NOBRANCH`, `RegWrite`/`BranchType` encodings and ALU codes come from the shared core parameter header. No new local encodings are introduced.
- Bubble constant fields are defined once as localparams.
- One sub-module: `load_use_detect`, purely combinational (inputs: E load info, D source indices, `RegReadD`; output: `lu`). It is reused by the forwarding/hazard top-level.

## Test plan
- Load then dependent use: `lw x5,0(x1)` in E (`MemToRegE=1`, `RdE=5`), `add x6,x5,x2` in D (`RegReadD=2'b11`, `Rs1D=5`). Required: `stall_fd=1` for one cycle, next E is the bubble (`valid_e=0`, `RegWriteE=NOREGWRITE`), `bubble_cnt=1`. The following cycle the add enters E.
- Load to x0 (`RdE=0`) with `Rs1D=0`, and I-type D (`RegReadD=2'b10`) with `Rs2D==RdE` only. Required: `stall_fd=0` in both cases, and D passes through.
- `flush_e=1` simultaneous with a load-use condition. Required: `stall_fd=0`, E becomes bubble, `flush_cnt` += 1, `bubble_cnt` unchanged.
- `stall_e=1` for 3 cycles with a load-use pending. Required: E fields are unchanged all 3 cycles and `stall_fd=1` throughout. The bubble appears on the cycle after `stall_e` falls.
- Normal flow of `sw` (`MemWriteD=4'b1111`, `ImmD=0x10`, `PCD=0x100`). Required: next-cycle `MemWriteE=4'b1111`, `ImmE=0x10`, `PCE=0x100`, `valid_e=1`.
- Reset: assert `rst` with populated E. Required: bubble on all outputs and both counters 0. Preload `bubble_cnt` to all-ones (force) and trigger a bubble: required count stays all-ones.
